// File: rtl/datapath_v1_if.sv
// datapath_v1_if: control/status bundle between the accumulator-CPU
// controller (master) and the datapath (slave).
//   master drives : instr, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc,
//                   SelAcc, SelALU
//   master reads  : pc, op, z, c, acc_out
// Handshake: there is no valid/ready pair. Every strobe is a single-cycle
// command sampled at the rising clock edge, and every status output is a
// registered value that is stable between edges.
interface datapath_v1_if #(
  parameter int DW = 4,
  parameter int AW = 8
);
  logic [7:0]    instr;
  logic          LoadIR;
  logic          IncPC;
  logic          SelPC;
  logic          LoadPC;
  logic          LoadReg;
  logic          LoadAcc;
  logic [1:0]    SelAcc;
  logic [3:0]    SelALU;
  logic [AW-1:0] pc;
  logic [3:0]    op;
  logic          z;
  logic          c;
  logic [DW-1:0] acc_out;

  modport master (
    output instr, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
    input  pc, op, z, c, acc_out
  );

  modport slave (
    input  instr, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU,
    output pc, op, z, c, acc_out
  );
endinterface

// File: rtl/datapath_v1.sv
// datapath_v1: register-transfer datapath of the 4-bit accumulator CPU.
// Holds PC, IR, ACC, a 16-entry register file, the ALU and the Z/C flags.
// Ports:
//   clk  - sole clock, all state changes on posedge
//   CLB  - asynchronous active-low reset
//   bus  - datapath_v1_if.slave: controller strobes in; pc/op/z/c/acc_out out
// Optional feature: define DP_R0_ZERO_EN to hardwire R[0] to zero
// (writes to R0 are dropped, reads of R0 return 0).
// No FSM lives here; the sequencing is done by the controller.
module datapath_v1 #(
  parameter int DW = 4,
  parameter int AW = 8
) (
  input  logic        clk,
  input  logic        CLB,
  datapath_v1_if.slave bus
);

  logic [AW-1:0] r_pc;
  logic [7:0]    r_ir;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_regs [16];
  logic          r_z;
  logic          r_c;

  logic [3:0]    w_operand;
  logic [3:0]    w_op;
  logic [DW-1:0] w_rb;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_c;
  logic          w_alu_cw;
  logic          w_acc_we;
  logic [DW-1:0] w_acc_nxt;
  logic          w_take;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_tgt;
  logic          w_reg_we;

  assign w_operand = r_ir[3:0];
  assign w_op      = r_ir[7:4];

  // Register-file read port, shared by ALU operand B, MOVR and indirect jumps.
`ifdef DP_R0_ZERO_EN
  assign w_rb     = (w_operand == 4'd0) ? '0 : r_regs[w_operand];
  assign w_reg_we = bus.LoadReg && (w_operand != 4'd0);
`else
  assign w_rb     = r_regs[w_operand];
  assign w_reg_we = bus.LoadReg;
`endif

  // Extra top bit of the difference is the borrow (set iff A < B).
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_rb};
  assign w_diff = {1'b0, r_acc} - {1'b0, w_rb};

  always_comb begin
    w_alu_res = r_acc;
    w_alu_c   = r_c;
    w_alu_cw  = 1'b0;
    case (bus.SelALU)
      4'b0001: begin w_alu_res = w_sum[DW-1:0];  w_alu_c = w_sum[DW];  w_alu_cw = 1'b1; end
      4'b0010: begin w_alu_res = w_diff[DW-1:0]; w_alu_c = w_diff[DW]; w_alu_cw = 1'b1; end
      4'b0011: begin w_alu_res = ~(r_acc | w_rb); w_alu_c = 1'b0;      w_alu_cw = 1'b1; end
      4'b1011: begin w_alu_res = r_acc << 1;      w_alu_c = r_acc[DW-1]; w_alu_cw = 1'b1; end
      4'b1100: begin w_alu_res = r_acc >> 1;      w_alu_c = r_acc[0];  w_alu_cw = 1'b1; end
      default: ;
    endcase
  end

  // SelAcc=01 is reserved: it behaves like no write at all (ACC and flags hold).
  assign w_acc_we = bus.LoadAcc && (bus.SelAcc != 2'b01);

  always_comb begin
    w_acc_nxt = r_acc;
    case (bus.SelAcc)
      2'b00:   w_acc_nxt = w_alu_res;
      2'b10:   w_acc_nxt = w_rb;
      2'b11:   w_acc_nxt = DW'(w_operand);
      default: w_acc_nxt = r_acc;
    endcase
  end

  // Jump condition is decoded from the latched opcode, not from SelALU.
  always_comb begin
    w_take = 1'b0;
    case (w_op)
      4'b0110, 4'b0111: w_take = r_z;
      4'b1000, 4'b1010: w_take = r_c;
      default:          w_take = 1'b0;
    endcase
  end

  assign w_pc_inc = r_pc + AW'(1);
  assign w_pc_tgt = bus.SelPC ? AW'(w_rb) : AW'(w_operand);

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      r_pc  <= '0;
      r_ir  <= 8'h00;
      r_acc <= '0;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      if (bus.LoadIR) r_ir <= bus.instr;

      // LoadPC wins over IncPC; an untaken conditional jump still advances.
      if (bus.LoadPC)     r_pc <= w_take ? w_pc_tgt : w_pc_inc;
      else if (bus.IncPC) r_pc <= w_pc_inc;

      if (w_acc_we) begin
        r_acc <= w_acc_nxt;
        r_z   <= (w_acc_nxt == '0);
        if ((bus.SelAcc == 2'b00) && w_alu_cw) r_c <= w_alu_c;
      end

      // Stores the pre-edge ACC even when ACC is written in the same cycle.
      if (w_reg_we) r_regs[w_operand] <= r_acc;
    end
  end

  assign bus.pc      = r_pc;
  assign bus.op      = w_op;
  assign bus.z       = r_z;
  assign bus.c       = r_c;
  assign bus.acc_out = r_acc;

endmodule

// File: tb/tb_datapath_v1.sv
// tb_datapath_v1: directed bench for datapath_v1. The driver applies one
// command per clock and pushes the hand-computed architectural state
// {pc, op, acc, z, c} it requires after that edge; the monitor pops and
// compares on every falling edge while expectations are pending.
module tb_datapath_v1;
  localparam int DW = 4;
  localparam int AW = 8;
  localparam int W  = AW + 4 + DW + 2;

  logic clk;
  logic CLB;

  datapath_v1_if #(.DW(DW), .AW(AW)) bus();

  datapath_v1 #(.DW(DW), .AW(AW)) u_dut (
    .clk (clk),
    .CLB (CLB),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp_v;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      got   = {bus.pc, bus.op, bus.acc_out, bus.z, bus.c};
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL state#%0d t=%0t: got pc=%h op=%h acc=%h z=%b c=%b, want pc=%h op=%h acc=%h z=%b c=%b",
                 total, $time, got[W-1 -: AW], got[DW+5 -: 4], got[DW+1 -: DW], got[1], got[0],
                 exp_v[W-1 -: AW], exp_v[DW+5 -: 4], exp_v[DW+1 -: DW], exp_v[1], exp_v[0]);
      end
    end
  end

  // Driver tasks
  task automatic exp_push(input logic [AW-1:0] epc, input logic [3:0] eop,
                          input logic [DW-1:0] eacc, input logic ez, input logic ec);
    exp_q.push_back({epc, eop, eacc, ez, ec});
  endtask

  task automatic clr_ctl();
    bus.LoadIR = 0; bus.IncPC = 0; bus.SelPC = 0; bus.LoadPC = 0;
    bus.LoadReg = 0; bus.LoadAcc = 0; bus.SelAcc = 2'b00; bus.SelALU = 4'h0;
  endtask

  // One command cycle, then the state required after the edge.
  task automatic step(input logic [7:0] ins, input logic ldir, input logic inc,
                      input logic selpc, input logic ldpc, input logic ldreg,
                      input logic ldacc, input logic [1:0] sa, input logic [3:0] alu,
                      input logic [AW-1:0] epc, input logic [3:0] eop,
                      input logic [DW-1:0] eacc, input logic ez, input logic ec);
    bus.instr = ins; bus.LoadIR = ldir; bus.IncPC = inc; bus.SelPC = selpc;
    bus.LoadPC = ldpc; bus.LoadReg = ldreg; bus.LoadAcc = ldacc;
    bus.SelAcc = sa; bus.SelALU = alu;
    @(posedge clk);
    #1;
    clr_ctl();
    exp_push(epc, eop, eacc, ez, ec);
    @(negedge clk);
    #1;
  endtask

  task automatic ld_ir(input logic [7:0] ins, input logic [AW-1:0] epc, input logic [3:0] eop,
                       input logic [DW-1:0] eacc, input logic ez, input logic ec);
    step(ins, 1, 0, 0, 0, 0, 0, 2'b00, 4'h0, epc, eop, eacc, ez, ec);
  endtask

  task automatic ld_acc(input logic [1:0] sa, input logic [3:0] alu, input logic [AW-1:0] epc,
                        input logic [3:0] eop, input logic [DW-1:0] eacc, input logic ez,
                        input logic ec);
    step(8'h00, 0, 0, 0, 0, 0, 1, sa, alu, epc, eop, eacc, ez, ec);
  endtask

  initial begin
    int n;
    CLB = 1'b0;
    bus.instr = 8'h00;
    clr_ctl();
    repeat (2) @(negedge clk);
    #1;
    exp_push(8'h00, 4'h0, 4'h0, 0, 0);           // reset state
    @(negedge clk);
    #1;
    CLB = 1'b1;

    // Reset / fetch, then LDIM 5
    step(8'hD5, 1, 1, 0, 0, 0, 0, 2'b00, 4'h0, 8'h01, 4'hD, 4'h0, 0, 0);
    ld_acc(2'b11, 4'h0, 8'h01, 4'hD, 4'h5, 0, 0);

    // ADD carry: R3=1, ACC=F, ADD R3
    ld_ir(8'h01, 8'h01, 4'h0, 4'h5, 0, 0);
    ld_acc(2'b11, 4'h0, 8'h01, 4'h0, 4'h1, 0, 0);
    ld_ir(8'h03, 8'h01, 4'h0, 4'h1, 0, 0);
    step(8'h00, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 8'h01, 4'h0, 4'h1, 0, 0);   // R3 <= 1
    ld_ir(8'h0F, 8'h01, 4'h0, 4'h1, 0, 0);
    ld_acc(2'b11, 4'h0, 8'h01, 4'h0, 4'hF, 0, 0);
    ld_ir(8'h13, 8'h01, 4'h1, 4'hF, 0, 0);
    ld_acc(2'b00, 4'b0001, 8'h01, 4'h1, 4'h0, 1, 1);                       // F+1

    // SUB borrow: R1=5 (stored from old ACC while ACC loads 1), ACC=2
    ld_ir(8'h05, 8'h01, 4'h0, 4'h0, 1, 1);
    ld_acc(2'b11, 4'h0, 8'h01, 4'h0, 4'h5, 0, 1);
    ld_ir(8'h01, 8'h01, 4'h0, 4'h5, 0, 1);
    step(8'h00, 0, 0, 0, 0, 1, 1, 2'b11, 4'h0, 8'h01, 4'h0, 4'h1, 0, 1);   // R1 <= 5, ACC <= 1
    ld_ir(8'h02, 8'h01, 4'h0, 4'h1, 0, 1);
    ld_acc(2'b11, 4'h0, 8'h01, 4'h0, 4'h2, 0, 1);
    ld_ir(8'h21, 8'h01, 4'h2, 4'h2, 0, 1);
    ld_acc(2'b00, 4'b0010, 8'h01, 4'h2, 4'hD, 0, 1);                       // 2-5

    // MOVR R2 (=0): c holds
    ld_ir(8'h92, 8'h01, 4'h9, 4'hD, 0, 1);
    ld_acc(2'b10, 4'h0, 8'h01, 4'h9, 4'h0, 1, 1);
    // NOR, SHL, SHR, reserved SelAcc, non-ALU SelALU
    ld_acc(2'b00, 4'b0011, 8'h01, 4'h9, 4'hF, 0, 0);                       // ~(0|0)
    ld_acc(2'b00, 4'b1011, 8'h01, 4'h9, 4'hE, 0, 1);                       // F<<1
    ld_acc(2'b00, 4'b1100, 8'h01, 4'h9, 4'h7, 0, 0);                       // E>>1
    ld_acc(2'b01, 4'b0001, 8'h01, 4'h9, 4'h7, 0, 0);                       // reserved: hold
    // ADD R1 (5): 7+5 = C, no carry
    ld_ir(8'h01, 8'h01, 4'h0, 4'h7, 0, 0);
    ld_acc(2'b00, 4'b0001, 8'h01, 4'h0, 4'hC, 0, 0);

    // JZIM 9 with z=1, then with z=0
    ld_ir(8'h00, 8'h01, 4'h0, 4'hC, 0, 0);
    ld_acc(2'b11, 4'h0, 8'h01, 4'h0, 4'h0, 1, 0);
    ld_ir(8'h79, 8'h01, 4'h7, 4'h0, 1, 0);
    step(8'h00, 0, 0, 0, 1, 0, 0, 2'b00, 4'h0, 8'h09, 4'h7, 4'h0, 1, 0);
    ld_ir(8'h01, 8'h09, 4'h0, 4'h0, 1, 0);
    ld_acc(2'b11, 4'h0, 8'h09, 4'h0, 4'h1, 0, 0);
    ld_ir(8'h79, 8'h09, 4'h7, 4'h1, 0, 0);
    step(8'h00, 0, 0, 0, 1, 0, 0, 2'b00, 4'h0, 8'h0A, 4'h7, 4'h1, 0, 0);

    // JCRS R4 with R4=7, c=1
    ld_ir(8'h07, 8'h0A, 4'h0, 4'h1, 0, 0);
    ld_acc(2'b11, 4'h0, 8'h0A, 4'h0, 4'h7, 0, 0);
    ld_ir(8'h04, 8'h0A, 4'h0, 4'h7, 0, 0);
    step(8'h00, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 8'h0A, 4'h0, 4'h7, 0, 0);   // R4 <= 7
    ld_ir(8'h08, 8'h0A, 4'h0, 4'h7, 0, 0);
    ld_acc(2'b11, 4'h0, 8'h0A, 4'h0, 4'h8, 0, 0);
    ld_acc(2'b00, 4'b1011, 8'h0A, 4'h0, 4'h0, 1, 1);                       // 8<<1 -> c=1
    ld_ir(8'h84, 8'h0A, 4'h8, 4'h0, 1, 1);
    step(8'h00, 0, 0, 1, 1, 0, 0, 2'b00, 4'h0, 8'h07, 4'h8, 4'h0, 1, 1);

    // Walk PC up to FF, then wrap
    for (int i = 8; i < 256; i++)
      step(8'h00, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0, AW'(i), 4'h8, 4'h0, 1, 1);
    step(8'h00, 0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 8'h00, 4'h8, 4'h0, 1, 1);

    // LoadPC beats IncPC: taken JC immediate 3
    ld_ir(8'h83, 8'h00, 4'h8, 4'h0, 1, 1);
    step(8'h00, 0, 1, 0, 1, 0, 0, 2'b00, 4'h0, 8'h03, 4'h8, 4'h0, 1, 1);
    // LoadPC on a non-jump opcode just advances
    ld_ir(8'h53, 8'h03, 4'h5, 4'h0, 1, 1);
    step(8'h00, 0, 0, 0, 1, 0, 0, 2'b00, 4'h0, 8'h04, 4'h5, 4'h0, 1, 1);

    // MOVA to R0, then MOVR R0
    ld_ir(8'h06, 8'h04, 4'h0, 4'h0, 1, 1);
    ld_acc(2'b11, 4'h0, 8'h04, 4'h0, 4'h6, 0, 1);
    ld_ir(8'h00, 8'h04, 4'h0, 4'h6, 0, 1);
    step(8'h00, 0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 8'h04, 4'h0, 4'h6, 0, 1);
`ifdef DP_R0_ZERO_EN
    ld_acc(2'b10, 4'h0, 8'h04, 4'h0, 4'h0, 1, 1);
`else
    ld_acc(2'b10, 4'h0, 8'h04, 4'h0, 4'h6, 0, 1);
`endif

    // Asynchronous reset between edges clears everything at once
    @(posedge clk);
    #2;
    CLB = 1'b0;
    #1;
    exp_push(8'h00, 4'h0, 4'h0, 0, 0);
    @(negedge clk);
    #1;
    CLB = 1'b1;
    step(8'hA3, 1, 1, 0, 0, 0, 0, 2'b00, 4'h0, 8'h01, 4'hA, 4'h0, 0, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/datapath_v1.md
# datapath_v1

Register-transfer datapath that executes the control words of the 4-bit accumulator CPU. It holds PC, IR, ACC, a 16-entry register file, the ALU and the Z/C flags. It drives `op`, `z` and `c` back to the controller and `pc` out to program memory. It sits directly downstream of the controller FSM and consumes its LoadIR/IncPC/SelPC/LoadPC/LoadReg/LoadAcc/SelAcc/SelALU outputs.

## Interface
- `DW`, 4: data width of ACC, registers and ALU.
- `AW`, 8: PC / program-address width.
- `clk`  in  1: sole clock, all state updates on posedge.
- `CLB`  in  1: asynchronous active-low reset.
- `instr`  in  8: program-memory word at address `pc`; [7:4] opcode, [3:0] operand.
- `LoadIR`  in  1: IR <= instr.
- `IncPC`  in  1: PC <= PC+1.
- `SelPC`  in  1: jump source; 1 = R[operand], 0 = operand immediate.
- `LoadPC`  in  1: conditional jump strobe.
- `LoadReg`  in  1: R[operand] <= ACC.
- `LoadAcc`  in  1: ACC write strobe.
- `SelAcc`  in  2: ACC source select.
- `SelALU`  in  4: ALU operation (opcode encoding).
- `pc`  out  AW: current PC (program-memory address).
- `op`  out  4: IR[7:4].
- `z`  out  1: zero flag (registered).
- `c`  out  1: carry/borrow flag (registered).
- `acc_out`  out  DW: current ACC.

## Operation
- Reset (CLB=0, asynchronous): PC=0, IR=8'h00 (op=NOP), ACC=0, all R[i]=0, z=0, c=0. The block holds this state while CLB=0 and resumes on the first posedge after release.
- IR: loads `instr` on LoadIR; otherwise holds. `operand`=IR[3:0]; all operand uses read IR *before* the edge.
- PC priority: LoadPC > IncPC > hold.
  - LoadPC: `take` = z for op 0110/0111, c for op 1000/1010, 0 for any other op.
  - When `take`: PC <= SelPC ? zero-ext(R[operand][DW-1:0]) : zero-ext(operand).
  - When not `take`: PC <= PC+1.
  - PC+1 wraps from 2^AW-1 to 0.
- ACC on LoadAcc, by SelAcc:
  - 00: ALU result.
  - 10: R[operand].
  - 11: zero-ext(operand).
  - 01: reserved; ACC holds and flags hold.
- ALU (operand B = R[operand], all DW-bit, unsigned):
  - 0001 ADD: {c,res}=A+B.
  - 0010 SUB: res=A-B mod 2^DW; c=1 iff A<B (borrow).
  - 0011 NOR: res=~(A|B); c=0.
  - 1011 SHL: res=A<<1; c=A[DW-1].
  - 1100 SHR: res=A>>1 (logical); c=A[0].
  - Any other SelALU: res=A, c unchanged.
- Flags:
  - z <= (new ACC==0) on every ACC write with SelAcc≠01.
  - c is written only when SelAcc=00 and SelALU is one of the five ALU ops; MOVR/LDIM leave c unchanged.
- LoadReg: R[operand] <= ACC (old ACC if LoadAcc is asserted in the same cycle).
- Simultaneous strobes are legal; each register uses pre-edge values of all sources.

## Timing
- All outputs are registered; `pc`, `op`, `acc_out`, `z` and `c` change only after a posedge or asynchronously on reset.
- Strobe sampled at edge N → new value visible after edge N.
- `instr` must be valid for the current `pc` at the edge where LoadIR=1. Program memory is combinational relative to `pc`.
- The controller's fetch cycle (LoadIR=1, IncPC=1) latches instr@PC and advances PC in one edge.
- Jump latency is one cycle from LoadPC to the new `pc`.
- Reset asserted mid-instruction discards all in-flight state immediately; no partial writes complete.

## Configuration
- `DP_R0_ZERO_EN` defined:
  - R[0] is hardwired to 0.
  - LoadReg with operand 0 is ignored.
  - Reads of R0 (ALU B, MOVR, SelPC=1 jump) return 0.
- Not defined: R[0] is an ordinary writable register.

## Test plan
- Reset/fetch:
  - Stimulus: CLB low then high; instr=8'hD5; pulse LoadIR+IncPC.
  - Required: pc=1, op=4'hD.
  - Then LoadAcc with SelAcc=11: acc_out=5, z=0, c=0.
- ADD carry:
  - Stimulus: ACC=4'hF, R3=4'h1, IR operand 3; LoadAcc, SelAcc=00, SelALU=0001.
  - Required: acc_out=0, z=1, c=1.
- SUB borrow then MOVR:
  - Stimulus: ACC=2, R1=5; SUB.
  - Required: acc_out=4'hD, c=1, z=0.
  - Then MOVR from R2=0: acc_out=0, z=1, c stays 1.
- Conditional jump:
  - Stimulus: op=0111 (JZIM), operand=9, z=1; LoadPC.
  - Required: pc=9.
  - Repeat with z=0 from pc=9: pc=10.
  - With op=1000 (JCRS), SelPC=1, R4=7, c=1: pc=7.
- Wrap and priority:
  - Stimulus: pc=8'hFF, IncPC.
  - Required: pc=0.
  - LoadPC+IncPC with a taken jump to 3: pc=3.
- MOVA / R0 config:
  - Stimulus: ACC=6, LoadReg operand 0, then MOVR operand 0.
  - Required: acc_out=6 without macro; acc_out=0 and z=1 with `DP_R0_ZERO_EN`.
